// File: rtl/mux_ser_pkg.sv
// Shared definitions for the 16-bit parallel-to-serial converter.
//   state_t  : serializer FSM states (PAR is only reachable when the
//              SER_PARITY_EN macro is defined)
//   WORD_W   : parallel word width
//   SEL_W    : bit-select width
//   LAST_IDX : index of the final data bit in a frame
//   even_parity() : parity bit appended after bit 15 when SER_PARITY_EN is set
package mux_ser_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;
  localparam logic [SEL_W-1:0] LAST_IDX = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  function automatic logic even_parity(input logic [WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mux_16x1.sv
// 16:1 single-bit multiplexer used as the serializer's bit-select datapath.
//   data : 16-bit word to select from
//   sel  : bit index
//   y    : data[sel]
module mux_16x1
  import mux_ser_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  assign y = data[sel];

endmodule

// File: rtl/mux_serializer_16.sv
// Parallel-to-serial converter: accepts a 16-bit word over a valid/ready
// handshake and streams it out LSB first, one bit per accepted serial beat.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit (^word)
// after bit 15, giving 17-bit frames.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : producer offers in_data
//   in_ready     : block can take a word this cycle
//   in_data      : parallel word, bit 0 sent first
//   ser_ready    : consumer takes the current serial bit
//   ser_valid    : ser_out carries a frame bit
//   ser_out      : current serial bit
//   sel          : current bit index (debug)
//   frame_start  : bit 0 of a frame is being presented
//   frame_done   : last bit of a frame is taken this cycle
module mux_serializer_16
  import mux_ser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              ser_ready,
  output logic              ser_valid,
  output logic              ser_out,
  output logic [SEL_W-1:0]  sel,
  output logic              frame_start,
  output logic              frame_done
);

  state_t            state;
  logic [WORD_W-1:0] hold;
  logic [SEL_W-1:0]  cnt;
  logic              mux_bit;
  logic              last_bit;
  logic              accept;

  mux_16x1 u_mux (
    .data (hold),
    .sel  (cnt),
    .y    (mux_bit)
  );

`ifdef SER_PARITY_EN
  assign last_bit = (state == PAR);
`else
  assign last_bit = (state == SHIFT) && (cnt == LAST_IDX);
`endif

  // A new word may load in the final-bit beat so frames run gapless.
  assign ser_valid   = (state != IDLE);
  assign in_ready    = (state == IDLE) || (last_bit && ser_ready);
  assign accept      = in_valid && in_ready;
  assign frame_done  = ser_valid && ser_ready && last_bit;
  assign frame_start = ser_valid && (state == SHIFT) && (cnt == '0);
  assign sel         = cnt;

  always_comb begin
    ser_out = 1'b0;
    case (state)
      SHIFT:   ser_out = mux_bit;
`ifdef SER_PARITY_EN
      PAR:     ser_out = even_parity(hold);
`endif
      default: ser_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      hold  <= in_data;
      cnt   <= '0;
      state <= SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          if (ser_ready) begin
            if (cnt == LAST_IDX) begin
`ifdef SER_PARITY_EN
              // cnt stays at 15 while the parity bit is presented
              state <= PAR;
`else
              state <= IDLE;
              cnt   <= '0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          if (ser_ready) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serializer_16.sv
// Self-checking bench for mux_serializer_16: directed scenarios plus random
// traffic, compared each cycle against a queue-based model of the frame
// stream. Define SER_PARITY_EN to check the parity build.
module tb_mux_serializer_16;

`ifdef SER_PARITY_EN
  localparam int FL = 17;
`else
  localparam int FL = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        ser_ready;
  logic        ser_valid;
  logic        ser_out;
  logic [3:0]  sel;
  logic        frame_start;
  logic        frame_done;

  mux_serializer_16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .ser_ready   (ser_ready),
    .ser_valid   (ser_valid),
    .ser_out     (ser_out),
    .sel         (sel),
    .frame_start (frame_start),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model: remaining bits of the frame in flight (empty = idle)
  bit q[$];

  // DUT samples captured by the last cyc() call
  logic dut_bit, dut_valid, dut_done;
  logic last_acc;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  task automatic load_word(input logic [15:0] w);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(w[i]);
    if (FL == 17) q.push_back(^w);
  endtask

  // One clock cycle: apply inputs, compare at negedge, advance model at posedge.
  task automatic cyc(input logic iv, input logic [15:0] d, input logic sr);
    int   sz, pos;
    logic ev, eo, er, es, ed;
    logic [3:0] esel;
    in_valid  = iv;
    in_data   = d;
    ser_ready = sr;
    @(negedge clk);
    sz   = q.size();
    ev   = (sz > 0);
    pos  = FL - sz;
    eo   = 1'b0;
    if (ev) eo = q[0];
    esel = ev ? ((pos > 15) ? 4'd15 : 4'(pos)) : 4'd0;
    es   = ev && (pos == 0);
    ed   = ev && sr && (sz == 1);
    er   = !ev || ((sz == 1) && sr);
    check("in_ready",    16'(in_ready),    16'(er));
    check("ser_valid",   16'(ser_valid),   16'(ev));
    check("ser_out",     16'(ser_out),     16'(eo));
    check("sel",         16'(sel),         16'(esel));
    check("frame_start", 16'(frame_start), 16'(es));
    check("frame_done",  16'(frame_done),  16'(ed));
    dut_bit   = ser_out;
    dut_valid = ser_valid;
    dut_done  = frame_done;
    @(posedge clk);
    last_acc = iv && er;
    if (ev && sr) void'(q.pop_front());
    if (last_acc) load_word(d);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready",    16'(in_ready),    16'd1);
    check("rst_ser_valid",   16'(ser_valid),   16'd0);
    check("rst_ser_out",     16'(ser_out),     16'd0);
    check("rst_sel",         16'(sel),         16'd0);
    check("rst_frame_start", 16'(frame_start), 16'd0);
    check("rst_frame_done",  16'(frame_done),  16'd0);
  endtask

  // Assert reset between edges, verify async clear, hold 3 cycles, release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    q.delete();
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    int          c;
    bit          s[$];
    logic [15:0] ones, zeros;

    in_valid = 1'b0; in_data = '0; ser_ready = 1'b0;
    last_acc = 1'b0; dut_bit = 1'b0; dut_valid = 1'b0; dut_done = 1'b0;
    #2;
    do_reset();

    // idle after reset
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1);

    // single word A5C3, no back-pressure
    cyc(1'b1, 16'hA5C3, 1'b1);
    w = '0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 16'h0, 1'b1);
      w[i] = dut_bit;
      if (i == 15 && FL == 16) check("a5c3_done", 16'(dut_done), 16'd1);
    end
    check("a5c3_word", w, 16'hA5C3);
    if (FL == 17) begin
      cyc(1'b0, 16'h0, 1'b1);
      check("a5c3_parity", 16'(dut_bit), 16'd0);
      check("a5c3_par_done", 16'(dut_done), 16'd1);
    end
    cyc(1'b0, 16'h0, 1'b1);

    // back-pressure on frame cycles 3..6
    cyc(1'b1, 16'h0001, 1'b1);
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, 16'h0, !(i >= 3 && i <= 6));
      if (dut_done) begin c = i; break; end
    end
    check("bp_frame_cycles", 16'(c), 16'(FL + 4));

    // back-to-back FFFF then 0000
    cyc(1'b1, 16'hFFFF, 1'b1);
    s.delete();
    begin
      bit second = 0;
      for (int i = 0; i < 60; i++) begin
        cyc(!second, 16'h0000, 1'b1);
        if (dut_valid) s.push_back(dut_bit);
        else break;
        if (last_acc) second = 1;
      end
    end
    check("b2b_len", 16'(s.size()), 16'(2 * FL));
    ones = '0; zeros = '1;
    for (int i = 0; i < 16; i++) begin
      if (i < s.size()) ones[i] = s[i];
      if (FL + i < s.size()) zeros[i] = s[FL + i];
    end
    check("b2b_ones", ones, 16'hFFFF);
    check("b2b_zeros", zeros, 16'h0000);

    // reset mid-frame at sel=7 of 1234
    cyc(1'b1, 16'h1234, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 16'h0, 1'b1);
    check("mid_sel7_model", 16'(FL - q.size()), 16'd7);
    do_reset();
    cyc(1'b1, 16'h0003, 1'b1);
    w = '0;
    for (int i = 0; i < FL; i++) begin
      cyc(1'b0, 16'h0, 1'b1);
      if (i < 16) w[i] = dut_bit;
    end
    check("post_rst_word", w, 16'h0003);

    // single-bit walk
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 16'(1) << k, 1'b1);
      for (int i = 0; i < FL; i++) cyc(1'b0, 16'h0, 1'b1);
    end

    // random traffic
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom % 2), 16'($urandom), ($urandom % 4) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
